vip_axi4_mem_responder: RTL and testbench
=========================================

// Module: vip_axi4_mem_responder
// PURPOSE
//   AXI4 subordinate (responder) end of the VIP AXI4 bus: accepts AW/W bursts, stores strobed data in an
//   internal word RAM and returns B; accepts AR bursts and returns R beats from the same RAM.
//   Used as a behavioural memory target behind DUT managers in VIP testbenches.
//   Write and read paths are independent; one outstanding transaction per direction.
// PARAMETERS
//   ID_WIDTH_P    4    awid/bid/arid/rid width
//   ADDR_WIDTH_P  16   byte address width
//   DATA_WIDTH_P  32   data width, 32 or 64
//   STRB_WIDTH_P  DATA_WIDTH_P/8   write strobe width
//   MEM_DEPTH_P   256  RAM words (DATA_WIDTH_P each); power of two
// PORTS
//   clk      in   1      clock, all logic on rising edge
//   rst      in   1      synchronous reset, active-high
//   awid     in   ID     write burst id
//   awaddr   in   ADDR   write start byte address
//   awlen    in   8      beats-1
//   awsize   in   3      log2 bytes/beat, must be <= log2(STRB_WIDTH_P)
//   awburst  in   2      FIXED=0, INCR=1, WRAP=2
//   awvalid/awready  in/out 1   AW handshake
//   wdata    in   DATA   write data
//   wstrb    in   STRB   byte enables
//   wlast    in   1      last write beat
//   wvalid/wready    in/out 1   W handshake
//   bid      out  ID     = captured awid
//   bresp    out  2      write response
//   bvalid/bready    out/in 1   B handshake
//   arid, araddr, arlen, arsize, arburst   in   as aw*   read burst request
//   arvalid/arready  in/out 1   AR handshake
//   rid      out  ID     = captured arid
//   rdata    out  DATA   read data
//   rresp    out  2      read response
//   rlast    out  1      last read beat
//   rvalid/rready    out/in 1   R handshake
// BEHAVIOUR
//   Reset: awready=arready=0 in reset, 1 from the first cycle after; wready=bvalid=rvalid=rlast=0;
//   bid=rid=0; bresp=rresp=0; rdata=0. RAM contents not reset. Reset mid-burst: both FSMs go idle,
//   partial burst dropped, beats already written stay written.
//   Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   - W_IDLE: awready=1. AW handshake captures id/addr/len/size/burst, zeroes the beat counter -> W_DATA.
//   - W_DATA: wready=1. Each W handshake writes strobed bytes to word addr[ADDR-1:log2(STRB)].
//     INCR: addr += 1<<size. FIXED: addr is held. Burst ends when beat count == len.
//     Then -> W_RESP the next cycle with bvalid=1.
//   - W_RESP: bvalid held with stable bid/bresp until bready -> W_IDLE. awready=0 while not W_IDLE.
//   - bresp priority: DECERR(3) if any beat word index >= MEM_DEPTH_P (that beat is not written);
//     else SLVERR(2) if burst is WRAP (no beats written) or wlast != (beat==len) on any beat;
//     else OKAY(0).
//   Read FSM R_IDLE -> R_DATA -> R_IDLE:
//   - AR handshake captures request; rvalid=1 the next cycle.
//   - rdata = RAM word of the current address, registered. rlast=1 only on beat len.
//   - rid/rdata/rresp/rlast held stable while rvalid && !rready.
//   - Each R handshake advances to the next beat, one beat per cycle under constant rready.
//   - After the last handshake -> R_IDLE with rvalid=0 the same edge.
//   - Per-beat rresp: out of range -> DECERR with rdata=0; WRAP -> SLVERR with rdata=0; else OKAY.
//   Same-cycle write and read of one word: the read returns the old value.
//   Beat counter is 8 bits, so len=255 gives 256 beats. Address increments wrap modulo 2^ADDR_WIDTH_P.
// STRUCTURE
//   Add to vip_axi4_types_pkg:
//   - AXI4_RESP_OKAY/EXOKAY/SLVERR/DECERR
//   - AXI4_BURST_FIXED/INCR/WRAP
//   - vip_axi4_wr_state_t, vip_axi4_rd_state_t enums
//   Sub-module vip_axi4_mem_responder_ram: MEM_DEPTH_P x DATA_WIDTH_P RAM with one byte-enable
//   write port and one registered read port.
// TESTING
//   1 AW id=3 addr=0x10 len=0, W 0xDEADBEEF strb=F wlast=1 -> bvalid next cycle, bid=3, bresp=0;
//     AR id=3 addr=0x10 -> rdata=0xDEADBEEF, rlast=1, rresp=0.
//   2 INCR len=3 size=2 addr=0x100 data 1,2,3,4 then read the same burst -> 4 beats 1,2,3,4,
//     rlast on beat 4 only.
//   3 Word 0x20 holds 0x11223344; write 0xAABBCCDD strb=4'b0101 -> readback 0x11BB33DD.
//   4 rready toggled 1/0 over an 8-beat read -> rdata stable while stalled, all 8 beats in order;
//     bready low 5 cycles -> bvalid held, awready=0.
//   5 addr=0x400 with MEM_DEPTH_P=256 -> bresp=3; read -> rresp=3, rdata=0; word 0 unchanged.
//   6 rst high after beat 3 of an 8-beat read -> next cycle rvalid=0; arready=1 after rst drops;
//     new read returns correct data.

Source files
------------

// File: rtl/vip_axi4_types_pkg.sv
// Shared AXI4 VIP types: response and burst encodings plus the responder FSM state enums.
package vip_axi4_types_pkg;

   localparam logic [1:0] AXI4_RESP_OKAY   = 2'd0;
   localparam logic [1:0] AXI4_RESP_EXOKAY = 2'd1;
   localparam logic [1:0] AXI4_RESP_SLVERR = 2'd2;
   localparam logic [1:0] AXI4_RESP_DECERR = 2'd3;

   localparam logic [1:0] AXI4_BURST_FIXED = 2'd0;
   localparam logic [1:0] AXI4_BURST_INCR  = 2'd1;
   localparam logic [1:0] AXI4_BURST_WRAP  = 2'd2;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } vip_axi4_wr_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } vip_axi4_rd_state_t;

endpackage

// File: rtl/vip_axi4_mem_responder_ram.sv
// Word RAM with a byte-enabled write port and a registered, read-first read port.
module vip_axi4_mem_responder_ram #(
   parameter int DATA_WIDTH_P = 32,
   parameter int MEM_DEPTH_P  = 256
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(MEM_DEPTH_P)-1:0] waddr,
   input  logic [DATA_WIDTH_P-1:0]        wdata,
   input  logic [DATA_WIDTH_P/8-1:0]      wstrb,
   input  logic                           re,
   input  logic [$clog2(MEM_DEPTH_P)-1:0] raddr,
   output logic [DATA_WIDTH_P-1:0]        rdata
);

   // One independent byte-wide array per lane keeps byte enables trivially mappable.
   for (genvar gi = 0; gi < DATA_WIDTH_P / 8; gi++) begin : g_lane
      logic [7:0] mem [MEM_DEPTH_P];
      logic [7:0] q_reg;

      always_ff @(posedge clk) begin
         if (we && wstrb[gi]) begin
            mem[waddr] <= wdata[gi*8 +: 8];
         end
         if (re) begin
            q_reg <= mem[raddr];
         end
      end

      assign rdata[gi*8 +: 8] = q_reg;
   end

endmodule

// File: rtl/vip_axi4_mem_responder.sv
// AXI4 memory responder: independent write (AW/W/B) and read (AR/R) FSMs over a shared word RAM,
// one outstanding burst per direction.
module vip_axi4_mem_responder
   import vip_axi4_types_pkg::*;
#(
   parameter int ID_WIDTH_P   = 4,
   parameter int ADDR_WIDTH_P = 16,
   parameter int DATA_WIDTH_P = 32,
   parameter int STRB_WIDTH_P = DATA_WIDTH_P / 8,
   parameter int MEM_DEPTH_P  = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ID_WIDTH_P-1:0]   awid,
   input  logic [ADDR_WIDTH_P-1:0] awaddr,
   input  logic [7:0]              awlen,
   input  logic [2:0]              awsize,
   input  logic [1:0]              awburst,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH_P-1:0] wdata,
   input  logic [STRB_WIDTH_P-1:0] wstrb,
   input  logic                    wlast,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [ID_WIDTH_P-1:0]   bid,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ID_WIDTH_P-1:0]   arid,
   input  logic [ADDR_WIDTH_P-1:0] araddr,
   input  logic [7:0]              arlen,
   input  logic [2:0]              arsize,
   input  logic [1:0]              arburst,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [ID_WIDTH_P-1:0]   rid,
   output logic [DATA_WIDTH_P-1:0] rdata,
   output logic [1:0]              rresp,
   output logic                    rlast,
   output logic                    rvalid,
   input  logic                    rready
);

   localparam int BYTE_SHIFT = $clog2(STRB_WIDTH_P);
   localparam int WORD_W     = ADDR_WIDTH_P - BYTE_SHIFT;
   localparam int RAM_AW     = $clog2(MEM_DEPTH_P);
   localparam logic [ADDR_WIDTH_P-1:0] ADDR_ONE = ADDR_WIDTH_P'(1);

   // write path state
   vip_axi4_wr_state_t      w_state_reg;
   logic                    awready_reg, wready_reg, bvalid_reg;
   logic [ID_WIDTH_P-1:0]   bid_reg;
   logic [1:0]              bresp_reg;
   logic [ADDR_WIDTH_P-1:0] w_addr_reg;
   logic [7:0]              w_len_reg, w_beat_reg;
   logic [2:0]              w_size_reg;
   logic [1:0]              w_burst_reg;
   logic                    w_decerr_reg, w_slverr_reg;

   // read path state
   vip_axi4_rd_state_t      r_state_reg;
   logic                    arready_reg, rvalid_reg, rlast_reg, r_zero_reg;
   logic [ID_WIDTH_P-1:0]   rid_reg;
   logic [1:0]              rresp_reg;
   logic [ADDR_WIDTH_P-1:0] r_addr_reg;
   logic [7:0]              r_len_reg, r_beat_reg;
   logic [2:0]              r_size_reg;
   logic [1:0]              r_burst_reg;

   logic                    aw_fire, w_fire, ar_fire, r_fire;
   logic [WORD_W-1:0]       w_idx, rd_idx;
   logic                    w_in_range, w_last_beat, w_decerr_next, w_slverr_next;
   logic [ADDR_WIDTH_P-1:0] w_addr_adv, r_addr_adv, rd_addr;
   logic [1:0]              rd_burst, rd_resp;
   logic                    ram_we, ram_re;
   logic [DATA_WIDTH_P-1:0] ram_q;

   always_comb begin
      aw_fire       = awvalid && awready_reg;
      w_fire        = wvalid && wready_reg;
      w_idx         = w_addr_reg[ADDR_WIDTH_P-1:BYTE_SHIFT];
      w_in_range    = ((w_idx >> RAM_AW) == '0);
      w_last_beat   = (w_beat_reg == w_len_reg);
      w_decerr_next = w_decerr_reg || !w_in_range;
      w_slverr_next = w_slverr_reg || (w_burst_reg == AXI4_BURST_WRAP) || (wlast != w_last_beat);
      w_addr_adv    = (w_burst_reg == AXI4_BURST_FIXED) ? w_addr_reg
                                                        : w_addr_reg + (ADDR_ONE << w_size_reg);
      ram_we        = w_fire && w_in_range && (w_burst_reg != AXI4_BURST_WRAP);
   end

   // The RAM is read one beat ahead: on AR acceptance, then on every non-final R handshake.
   always_comb begin
      ar_fire    = arvalid && arready_reg;
      r_fire     = rvalid_reg && rready;
      r_addr_adv = (r_burst_reg == AXI4_BURST_FIXED) ? r_addr_reg
                                                     : r_addr_reg + (ADDR_ONE << r_size_reg);
      rd_addr    = ar_fire ? araddr : r_addr_adv;
      rd_burst   = ar_fire ? arburst : r_burst_reg;
      rd_idx     = rd_addr[ADDR_WIDTH_P-1:BYTE_SHIFT];
      rd_resp    = AXI4_RESP_OKAY;
      if ((rd_idx >> RAM_AW) != '0) begin
         rd_resp = AXI4_RESP_DECERR;
      end else if (rd_burst == AXI4_BURST_WRAP) begin
         rd_resp = AXI4_RESP_SLVERR;
      end
      ram_re     = ar_fire || (r_fire && !rlast_reg);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_reg <= W_IDLE;
         awready_reg <= 1'b0;
         wready_reg  <= 1'b0;
         bvalid_reg  <= 1'b0;
         bid_reg     <= '0;
         bresp_reg   <= AXI4_RESP_OKAY;
      end else begin
         case (w_state_reg)
            W_IDLE: begin
               awready_reg <= 1'b1;
               if (aw_fire) begin
                  bid_reg      <= awid;
                  w_addr_reg   <= awaddr;
                  w_len_reg    <= awlen;
                  w_size_reg   <= awsize;
                  w_burst_reg  <= awburst;
                  w_beat_reg   <= '0;
                  w_decerr_reg <= 1'b0;
                  w_slverr_reg <= 1'b0;
                  awready_reg  <= 1'b0;
                  wready_reg   <= 1'b1;
                  w_state_reg  <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  w_addr_reg   <= w_addr_adv;
                  w_beat_reg   <= w_beat_reg + 8'd1;
                  w_decerr_reg <= w_decerr_next;
                  w_slverr_reg <= w_slverr_next;
                  if (w_last_beat) begin
                     wready_reg  <= 1'b0;
                     bvalid_reg  <= 1'b1;
                     bresp_reg   <= w_decerr_next ? AXI4_RESP_DECERR :
                                    w_slverr_next ? AXI4_RESP_SLVERR : AXI4_RESP_OKAY;
                     w_state_reg <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid_reg  <= 1'b0;
                  awready_reg <= 1'b1;
                  w_state_reg <= W_IDLE;
               end
            end
            default: w_state_reg <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_reg <= R_IDLE;
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rlast_reg   <= 1'b0;
         rresp_reg   <= AXI4_RESP_OKAY;
         rid_reg     <= '0;
         r_zero_reg  <= 1'b1;
      end else begin
         case (r_state_reg)
            R_IDLE: begin
               arready_reg <= 1'b1;
               if (ar_fire) begin
                  rid_reg     <= arid;
                  r_addr_reg  <= araddr;
                  r_len_reg   <= arlen;
                  r_size_reg  <= arsize;
                  r_burst_reg <= arburst;
                  r_beat_reg  <= '0;
                  arready_reg <= 1'b0;
                  rvalid_reg  <= 1'b1;
                  rlast_reg   <= (arlen == 8'd0);
                  rresp_reg   <= rd_resp;
                  r_zero_reg  <= (rd_resp != AXI4_RESP_OKAY);
                  r_state_reg <= R_DATA;
               end
            end
            R_DATA: begin
               if (r_fire) begin
                  if (rlast_reg) begin
                     rvalid_reg  <= 1'b0;
                     rlast_reg   <= 1'b0;
                     arready_reg <= 1'b1;
                     r_state_reg <= R_IDLE;
                  end else begin
                     r_addr_reg <= r_addr_adv;
                     r_beat_reg <= r_beat_reg + 8'd1;
                     rlast_reg  <= ((r_beat_reg + 8'd1) == r_len_reg);
                     rresp_reg  <= rd_resp;
                     r_zero_reg <= (rd_resp != AXI4_RESP_OKAY);
                  end
               end
            end
            default: r_state_reg <= R_IDLE;
         endcase
      end
   end

   vip_axi4_mem_responder_ram #(
      .DATA_WIDTH_P (DATA_WIDTH_P),
      .MEM_DEPTH_P  (MEM_DEPTH_P)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (w_idx[RAM_AW-1:0]),
      .wdata (wdata),
      .wstrb (wstrb),
      .re    (ram_re),
      .raddr (rd_idx[RAM_AW-1:0]),
      .rdata (ram_q)
   );

   assign awready = awready_reg;
   assign wready  = wready_reg;
   assign bvalid  = bvalid_reg;
   assign bid     = bid_reg;
   assign bresp   = bresp_reg;
   assign arready = arready_reg;
   assign rvalid  = rvalid_reg;
   assign rlast   = rlast_reg;
   assign rresp   = rresp_reg;
   assign rid     = rid_reg;
   assign rdata   = r_zero_reg ? '0 : ram_q;

endmodule

// File: tb/tb_vip_axi4_mem_responder.sv
// Directed bench for vip_axi4_mem_responder: write/read bursts, strobes, stalls, errors, mid-burst reset.
module tb_vip_axi4_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  awid = '0, arid = '0, bid, rid;
   logic [15:0] awaddr = '0, araddr = '0;
   logic [7:0]  awlen = '0, arlen = '0;
   logic [2:0]  awsize = '0, arsize = '0;
   logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
   logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
   logic        arvalid = 1'b0, rready = 1'b0;
   logic        awready, wready, bvalid, arready, rvalid, rlast;
   logic [31:0] wdata = '0, rdata;
   logic [3:0]  wstrb = '0;

   int checks = 0;
   int errors = 0;
   logic [31:0] wbeats [16];
   logic [31:0] rexp   [16];

   always #5 clk = ~clk;

   vip_axi4_mem_responder dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input int bstall);
      int n;
      awid = id; awaddr = addr; awlen = len; awsize = 3'd2; awburst = burst; awvalid = 1'b1;
      n = 0;
      while (!awready && n < 50) begin tick; n++; end
      check("aw_accept", 64'(awready), 64'(1));
      tick;
      awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         wdata = wbeats[b]; wstrb = strb; wlast = (b == int'(len)); wvalid = 1'b1;
         n = 0;
         while (!wready && n < 50) begin tick; n++; end
         check("w_accept", 64'(wready), 64'(1));
         tick;
      end
      wvalid = 1'b0; wlast = 1'b0;
      check("bvalid", 64'(bvalid), 64'(1));
      check("bid", 64'(bid), 64'(id));
      check("bresp", 64'(bresp), 64'(exp_resp));
      for (int c = 0; c < bstall; c++) begin
         tick;
         check("bvalid_hold", 64'(bvalid), 64'(1));
         check("awready_blocked", 64'(awready), 64'(0));
         check("bid_hold", 64'(bid), 64'(id));
      end
      bready = 1'b1;
      tick;
      bready = 1'b0;
      check("bvalid_clear", 64'(bvalid), 64'(0));
      $display("write id=%0d addr=0x%0h len=%0d burst=%0d bresp=%0d", id, addr, len, burst, bresp);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [1:0] exp_resp,
                          input bit stall, input int abort_after);
      int n;
      arid = id; araddr = addr; arlen = len; arsize = 3'd2; arburst = burst; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 50) begin tick; n++; end
      check("ar_accept", 64'(arready), 64'(1));
      tick;
      arvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         if (b == abort_after) begin
            rready = 1'b0;
            $display("read id=%0d addr=0x%0h aborted after %0d beats", id, addr, b);
            return;
         end
         check("rvalid", 64'(rvalid), 64'(1));
         check("rdata", 64'(rdata), 64'(rexp[b]));
         check("rlast", 64'(rlast), 64'(b == int'(len)));
         check("rresp", 64'(rresp), 64'(exp_resp));
         check("rid", 64'(rid), 64'(id));
         if (stall) begin
            rready = 1'b0;
            tick;
            check("rvalid_stall", 64'(rvalid), 64'(1));
            check("rdata_stall", 64'(rdata), 64'(rexp[b]));
            check("rlast_stall", 64'(rlast), 64'(b == int'(len)));
         end
         rready = 1'b1;
         tick;
         rready = 1'b0;
      end
      check("rvalid_clear", 64'(rvalid), 64'(0));
      $display("read id=%0d addr=0x%0h len=%0d burst=%0d rresp=%0d", id, addr, len, burst, exp_resp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tick; tick;
      check("rst_awready", 64'(awready), 64'(0));
      check("rst_arready", 64'(arready), 64'(0));
      check("rst_wready", 64'(wready), 64'(0));
      check("rst_bvalid", 64'(bvalid), 64'(0));
      check("rst_rvalid", 64'(rvalid), 64'(0));
      check("rst_rlast", 64'(rlast), 64'(0));
      check("rst_ids", 64'({bid, rid}), 64'(0));
      check("rst_resps", 64'({bresp, rresp}), 64'(0));
      check("rst_rdata", 64'(rdata), 64'(0));
      rst = 1'b0;
      tick;
      check("post_rst_awready", 64'(awready), 64'(1));
      check("post_rst_arready", 64'(arready), 64'(1));

      // single beat write and readback
      wbeats[0] = 32'hDEADBEEF;
      do_write(4'd3, 16'h0010, 8'd0, 2'd1, 4'hF, 2'd0, 0);
      rexp[0] = 32'hDEADBEEF;
      do_read(4'd3, 16'h0010, 8'd0, 2'd1, 2'd0, 1'b0, -1);

      // 4-beat INCR burst, back-to-back read
      for (int i = 0; i < 4; i++) begin wbeats[i] = 32'(i + 1); rexp[i] = 32'(i + 1); end
      do_write(4'd5, 16'h0100, 8'd3, 2'd1, 4'hF, 2'd0, 0);
      do_read(4'd6, 16'h0100, 8'd3, 2'd1, 2'd0, 1'b0, -1);

      // partial strobes merge with old word contents
      wbeats[0] = 32'h11223344;
      do_write(4'd1, 16'h0020, 8'd0, 2'd1, 4'hF, 2'd0, 0);
      wbeats[0] = 32'hAABBCCDD;
      do_write(4'd1, 16'h0020, 8'd0, 2'd1, 4'b0101, 2'd0, 0);
      rexp[0] = 32'h11BB33DD;
      do_read(4'd1, 16'h0020, 8'd0, 2'd1, 2'd0, 1'b0, -1);

      // 8-beat burst with B backpressure, then read with R stalls
      for (int i = 0; i < 8; i++) begin wbeats[i] = 32'hA0 + 32'(i); rexp[i] = 32'hA0 + 32'(i); end
      do_write(4'd9, 16'h0200, 8'd7, 2'd1, 4'hF, 2'd0, 5);
      do_read(4'd9, 16'h0200, 8'd7, 2'd1, 2'd0, 1'b1, -1);

      // out-of-range address aliases word 0 in the RAM index but must not touch it
      wbeats[0] = 32'hCAFEF00D;
      do_write(4'd2, 16'h0000, 8'd0, 2'd1, 4'hF, 2'd0, 0);
      wbeats[0] = 32'h12345678;
      do_write(4'd2, 16'h0400, 8'd0, 2'd1, 4'hF, 2'd3, 0);
      rexp[0] = 32'h0;
      do_read(4'd2, 16'h0400, 8'd0, 2'd1, 2'd3, 1'b0, -1);
      rexp[0] = 32'hCAFEF00D;
      do_read(4'd2, 16'h0000, 8'd0, 2'd1, 2'd0, 1'b0, -1);

      // FIXED burst overwrites one word; WRAP is rejected with SLVERR
      wbeats[0] = 32'h5; wbeats[1] = 32'h6;
      do_write(4'd4, 16'h0040, 8'd1, 2'd0, 4'hF, 2'd0, 0);
      rexp[0] = 32'h6;
      do_read(4'd4, 16'h0040, 8'd0, 2'd1, 2'd0, 1'b0, -1);
      do_write(4'd8, 16'h0300, 8'd1, 2'd2, 4'hF, 2'd2, 0);
      rexp[0] = 32'h0; rexp[1] = 32'h0;
      do_read(4'd8, 16'h0300, 8'd1, 2'd2, 2'd2, 1'b0, -1);

      // reset in the middle of a read burst
      for (int i = 0; i < 8; i++) rexp[i] = 32'hA0 + 32'(i);
      do_read(4'd7, 16'h0200, 8'd7, 2'd1, 2'd0, 1'b0, 3);
      rst = 1'b1;
      tick;
      check("midrst_rvalid", 64'(rvalid), 64'(0));
      check("midrst_rlast", 64'(rlast), 64'(0));
      rst = 1'b0;
      tick;
      check("midrst_arready", 64'(arready), 64'(1));
      check("midrst_awready", 64'(awready), 64'(1));
      for (int i = 0; i < 4; i++) rexp[i] = 32'(i + 1);
      do_read(4'd7, 16'h0100, 8'd3, 2'd1, 2'd0, 1'b0, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
